example_6_2_2: RTL and testbench

EXAMPLE_6_2_2 -- requirements
Module: example_6_2_2

---
 rtl/example_6_2_2_pkg.sv | 21 ++
 rtl/example_6_2_2_pulse_detect.sv | 72 +++++++
 rtl/example_6_2_2.sv | 98 +++++++++
 tb/tb_example_6_2_2.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/example_6_2_2_pkg.sv
// Shared types and constants for the example_6_2_2 x1->x2->x3 sequence
// detector.
//   state_t      : 2-bit state {y2,y1}. The values are A=00, B=01, C=10 and
//                  ILLEGAL=11.
//   RESET_STATE  : the state that reset loads.
//   RESET_Z      : the value that reset loads into the z register.
//   EVENT_COUNT  : the number of x lines.
package example_6_2_2_pkg;

  typedef enum logic [1:0] {
    ST_A       = 2'b00,  // idle
    ST_B       = 2'b01,  // x1 seen
    ST_C       = 2'b10,  // x1, x2 seen
    ST_ILLEGAL = 2'b11   // unused encoding, recovers to A
  } state_t;

  localparam state_t RESET_STATE = ST_A;
  localparam logic   RESET_Z     = 1'b0;
  localparam int     EVENT_COUNT = 3;

endpackage

// File: rtl/example_6_2_2_pulse_detect.sv
// Turns one x line into a single-cycle event on its rising edge. When the
// line stays high, it produces only one event.
// Configuration macro EXAMPLE_6_2_2_SYNC_EN: when it is defined, the line
// first passes through a SYNC_STAGES-flop synchronizer.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   x   : raw input line
//   ex  : one-cycle rising-edge event
// After reset the event output stays masked until the edge detector has seen
// one real post-reset sample. This prevents a line that is held high through
// reset from counting as a new edge.
module example_6_2_2_pulse_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic x,
  output logic ex
);

  if (SYNC_STAGES < 2) begin : g_bad_param
    $error("SYNC_STAGES must be at least 2");
  end

  logic x_s;

`ifdef EXAMPLE_6_2_2_SYNC_EN
  localparam int ARM_CYCLES = SYNC_STAGES + 1;

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], x};
    end
  end

  assign x_s = sync_q[SYNC_STAGES-1];
`else
  localparam int ARM_CYCLES = 1;

  assign x_s = x;
`endif

  localparam int                AW      = $clog2(ARM_CYCLES + 1);
  localparam logic [AW-1:0]     ARM_MAX = AW'(ARM_CYCLES);

  logic          x_prev;
  logic [AW-1:0] arm_cnt;
  logic          armed;

  // NOTE: sequential state uses non-blocking assignments only. As a result,
  // every flop samples the values that existed before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_prev  <= 1'b0;
      arm_cnt <= '0;
    end else begin
      x_prev <= x_s;
      if (arm_cnt != ARM_MAX) begin
        arm_cnt <= arm_cnt + AW'(1);
      end
    end
  end

  assign armed = (arm_cnt == ARM_MAX);
  assign ex    = armed & x_s & ~x_prev;

endmodule

// File: rtl/example_6_2_2.sv
// Detects the ordered sequence x1 then x2 then x3 on three pulse lines.
// Configuration macro EXAMPLE_6_2_2_SYNC_EN: when it is defined, each x line
// is synchronized through SYNC_STAGES flops before edge detection.
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   x1, x2, x3 : input pulse lines
//   y2, y1     : registered state {MSB, LSB}
//   y2n, y1n   : registered complements of y2, y1
//   ny2, ny1   : combinational next-state bits
//   z          : registered one-cycle detection pulse
module example_6_2_2
  import example_6_2_2_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic x1,
  input  logic x2,
  input  logic x3,
  output logic y2,
  output logic y1,
  output logic y2n,
  output logic y1n,
  output logic ny2,
  output logic ny1,
  output logic z
);

  logic [EVENT_COUNT-1:0] x_in;
  logic [EVENT_COUNT-1:0] ev;

  assign x_in = {x3, x2, x1};

  for (genvar i = 0; i < EVENT_COUNT; i++) begin : g_pd
    example_6_2_2_pulse_detect #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_pd (
      .clk (clk),
      .rst (rst),
      .x   (x_in[i]),
      .ex  (ev[i])
    );
  end

  state_t state_q, state_d;
  logic   z_q, z_d;
  logic   y2n_q, y1n_q;
  logic   multi_ev;

  // Two or more events in the same cycle are treated as a broken sequence.
  assign multi_ev = (ev[0] & ev[1]) | (ev[0] & ev[2]) | (ev[1] & ev[2]);

  // NOTE: every output gets a default first, so that no path can infer a
  // latch.
  // Reset is also applied here. This keeps ny2/ny1 equal to the value that
  // the state register loads on every edge, including reset edges.
  always_comb begin
    state_d = state_q;
    z_d     = 1'b0;
    if (rst) begin
      state_d = RESET_STATE;
    end else if (state_q == ST_ILLEGAL || multi_ev) begin
      state_d = ST_A;
    end else if (ev[0]) begin
      state_d = ST_B;
    end else if (ev[1]) begin
      state_d = (state_q == ST_B) ? ST_C : ST_A;
    end else if (ev[2]) begin
      state_d = ST_A;
      z_d     = (state_q == ST_C);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_STATE;
      z_q     <= RESET_Z;
      y2n_q   <= ~RESET_STATE[1];
      y1n_q   <= ~RESET_STATE[0];
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      y2n_q   <= ~state_d[1];
      y1n_q   <= ~state_d[0];
    end
  end

  assign y2  = state_q[1];
  assign y1  = state_q[0];
  assign y2n = y2n_q;
  assign y1n = y1n_q;
  assign ny2 = state_d[1];
  assign ny1 = state_d[0];
  assign z   = z_q;

endmodule

// File: tb/tb_example_6_2_2.sv
// Self-checking bench for example_6_2_2. It uses directed sequences plus
// random traffic, and compares the DUT against a progress-count model of the
// sequence rules.
module tb_example_6_2_2;

`ifdef EXAMPLE_6_2_2_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic x1 = 1'b0, x2 = 1'b0, x3 = 1'b0;
  logic y2, y1, y2n, y1n, ny2, ny1, z;

  int total = 0;
  int bad   = 0;

  // Model: how far along the sequence we are (0, 1 or 2 symbols matched).
  int       m_prog = 0;
  bit       m_z    = 1'b0;
  bit [2:0] m_prev = '0;
  bit [2:0] m_hist [0:3];
  int       m_cyc  = 0;
  int       zcnt   = 0;

  always #5 clk = ~clk;

  example_6_2_2 #(.SYNC_STAGES(2)) dut (
    .clk (clk), .rst (rst), .x1 (x1), .x2 (x2), .x3 (x3),
    .y2 (y2), .y1 (y1), .y2n (y2n), .y1n (y1n),
    .ny2 (ny2), .ny1 (ny1), .z (z)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] enc(input int prog);
    return (prog == 1) ? 2'b01 : (prog == 2) ? 2'b10 : 2'b00;
  endfunction

  // Applies one cycle of stimulus, checks the next-state outputs before the
  // edge, advances the model, and checks the registers after the edge.
  task automatic tick(input bit a, input bit b, input bit c, input bit r);
    bit [2:0] xv, xs, ev;
    int       nprog, nev;
    bit       nz;
    x1 = a; x2 = b; x3 = c; rst = r;
    xv = {c, b, a};
    xs = (D == 0) ? xv : m_hist[D-1];
    ev = (m_cyc >= D + 1) ? (xs & ~m_prev) : 3'b000;
    nev = int'(ev[0]) + int'(ev[1]) + int'(ev[2]);
    nprog = m_prog;
    nz = 1'b0;
    if (r || nev >= 2) nprog = 0;
    else if (ev[0]) nprog = 1;
    else if (ev[1]) nprog = (m_prog == 1) ? 2 : 0;
    else if (ev[2]) begin nz = (m_prog == 2); nprog = 0; end
    @(negedge clk);
    check("ny", {6'd0, ny2, ny1}, {6'd0, enc(nprog)});
    @(posedge clk);
    #1;
    if (r) begin
      m_prev = '0; m_cyc = 0;
      for (int k = 0; k < 4; k++) m_hist[k] = '0;
    end else begin
      m_prev = xs; m_cyc++;
      for (int k = 3; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = xv;
    end
    m_prog = nprog;
    m_z = nz;
    if (z === 1'b1) zcnt++;
    check("state", {6'd0, y2, y1}, {6'd0, enc(m_prog)});
    check("compl", {6'd0, y2n, y1n}, {6'd0, ~enc(m_prog)});
    check("z", {7'd0, z}, {7'd0, m_z});
  endtask

  // Raises one line (1..3) for hi cycles, then keeps all lines low for lo cycles.
  task automatic pulse(input int line, input int hi, input int lo);
    for (int i = 0; i < hi; i++) tick(line == 1, line == 2, line == 3, 1'b0);
    for (int i = 0; i < lo; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  int stream [10]   = '{1, 2, 1, 3, 1, 2, 3, 1, 3, 2};
  logic [1:0] sexp [10] = '{2'b01, 2'b10, 2'b01, 2'b00, 2'b01,
                            2'b10, 2'b00, 2'b01, 2'b00, 2'b00};

  initial begin
    int z0;
    bit a, b, c;
    for (int k = 0; k < 4; k++) m_hist[k] = '0;

    // Reset: two reset cycles, then release.
    do_reset(2);
    check("rst_state", {6'd0, y2, y1}, 8'h00);
    check("rst_compl", {6'd0, y2n, y1n}, 8'h03);
    check("rst_z", {7'd0, z}, 8'h00);

    // A line held high through reset must not produce an event.
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("held_x1", {6'd0, y2, y1}, 8'h00);
    pulse(0, 0, 3);

    // Basic sequence: long pulses separated by long gaps.
    z0 = zcnt;
    pulse(1, 10, 20); check("seq_b", {6'd0, y2, y1}, 8'h01);
    pulse(2, 10, 20); check("seq_c", {6'd0, y2, y1}, 8'h02);
    pulse(3, 10, 20); check("seq_a", {6'd0, y2, y1}, 8'h00);
    check("seq_zcnt", 8'(zcnt - z0), 8'd1);

    // Mixed stream: z must appear exactly once, after the 7th pulse.
    for (int p = 0; p < 10; p++) begin
      z0 = zcnt;
      pulse(stream[p], 2, 5);
      check($sformatf("strm_st%0d", p), {6'd0, y2, y1}, {6'd0, sexp[p]});
      check($sformatf("strm_z%0d", p), 8'(zcnt - z0), (p == 6) ? 8'd1 : 8'd0);
    end

    // x1 and x2 rising together while in B breaks the sequence.
    pulse(1, 2, 5);
    check("dual_pre", {6'd0, y2, y1}, 8'h01);
    z0 = zcnt;
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
    pulse(0, 0, 5);
    check("dual_st", {6'd0, y2, y1}, 8'h00);
    check("dual_z", 8'(zcnt - z0), 8'd0);

    // Reset while in C, then x3: no detection.
    pulse(1, 2, 5); pulse(2, 2, 5);
    check("mid_pre", {6'd0, y2, y1}, 8'h02);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    check("mid_rst", {6'd0, y2, y1}, 8'h00);
    pulse(0, 0, 3);
    z0 = zcnt;
    pulse(3, 2, 5);
    check("mid_z", 8'(zcnt - z0), 8'd0);

    // Random traffic with occasional resets.
    a = 0; b = 0; c = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) a = ~a;
      if ($urandom_range(3) == 0) b = ~b;
      if ($urandom_range(3) == 0) c = ~c;
      tick(a, b, c, $urandom_range(199) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
